// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier sequencer.
package mult_pkg;

    localparam int unsigned WIDTH_DEFAULT      = 32;
    localparam logic [5:0]  ADDU_FUNCT_DEFAULT = 6'h21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/control_if.sv
// Control/datapath handshake bundle for the multiplier sequencer.
// master: the sequencer side; slave: the datapath/requester side.
interface control_if;

    logic       run;
    logic       lsb;
    logic       rdy;
    logic       w_ctrl_Multiplicand;
    logic       adding_ctrl;
    logic [5:0] addu_ctrl;
    logic       w_ctrl_Product;

    modport master (
        input  run,
        input  lsb,
        output rdy,
        output w_ctrl_Multiplicand,
        output adding_ctrl,
        output addu_ctrl,
        output w_ctrl_Product
    );

    modport slave (
        output run,
        output lsb,
        input  rdy,
        input  w_ctrl_Multiplicand,
        input  adding_ctrl,
        input  addu_ctrl,
        input  w_ctrl_Product
    );

endinterface

// File: rtl/control.sv
// Sequencer for the unsigned WIDTH x WIDTH shift-add multiplier.
// IDLE -> INIT (load) -> CALC (WIDTH add/shift steps) -> DONE.
// Optional build macro CTRL_AUTO_RESTART_EN: DONE with run held high goes
// straight back to INIT, giving back-to-back multiplies with one-cycle rdy.
module control
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEFAULT,
    parameter logic [5:0]  ADDU_FUNCT = ADDU_FUNCT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    control_if.master  bus
);

    localparam int unsigned    CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       rdy_q,  rdy_d;
    logic       wm_q,   wm_d;
    logic       wp_q,   wp_d;
    logic       calc_q, calc_d;
    logic [5:0] addu_q, addu_d;

    // State, counter and output registers; outputs are decoded from the
    // next state so they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            wm_q    <= 1'b0;
            wp_q    <= 1'b0;
            calc_q  <= 1'b0;
            addu_q  <= 6'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            wm_q    <= wm_d;
            wp_q    <= wp_d;
            calc_q  <= calc_d;
            addu_q  <= addu_d;
        end
    end

    // Next-state, iteration counter and next-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = 1'b0;
        wm_d    = 1'b0;
        wp_d    = 1'b0;
        calc_d  = 1'b0;
        addu_d  = 6'h00;

        case (state_q)
            IDLE: begin
                if (bus.run) state_d = INIT;
            end
            INIT: begin
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
`ifdef CTRL_AUTO_RESTART_EN
                state_d = bus.run ? INIT : IDLE;
`else
                if (!bus.run) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            INIT: begin
                wm_d = 1'b1;
                wp_d = 1'b1;
            end
            CALC: begin
                wp_d   = 1'b1;
                calc_d = 1'b1;
                addu_d = ADDU_FUNCT;
            end
            DONE:    rdy_d = 1'b1;
            default: ;
        endcase
    end

    // adding_ctrl follows the Product LSB within the same CALC cycle.
    assign bus.adding_ctrl         = calc_q & bus.lsb;
    assign bus.rdy                 = rdy_q;
    assign bus.w_ctrl_Multiplicand = wm_q;
    assign bus.w_ctrl_Product      = wp_q;
    assign bus.addu_ctrl           = addu_q;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the multiplier sequencer: per-cycle output checks
// plus a latency scoreboard (expected rdy latency queued when run is driven,
// popped when rdy is observed).
module tb_control;
    import mult_pkg::*;

    localparam int unsigned W   = WIDTH_DEFAULT;
    // Negedges from the one where run is driven to the one showing rdy.
    localparam int unsigned LAT = W + 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_q[$];

    control_if bus();

    control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] outs();
        return {bus.rdy, bus.w_ctrl_Multiplicand, bus.adding_ctrl,
                bus.addu_ctrl, bus.w_ctrl_Product};
    endfunction

    // ph: 0 idle, 1 init, 2 calc, 3 done
    function automatic logic [9:0] exp_vec(input int ph, input logic l);
        case (ph)
            1:       return {1'b0, 1'b1, 1'b0, 6'h00, 1'b1};
            2:       return {1'b0, 1'b0, l,    6'h21, 1'b1};
            3:       return {1'b1, 1'b0, 1'b0, 6'h00, 1'b0};
            default: return 10'h000;
        endcase
    endfunction

    task automatic start(input bit rel_rst);
        @(negedge clk);
        bus.run = 1'b1;
        if (rel_rst) rst = 1'b1;
        exp_q.push_back(LAT);
    endtask

    // Walk one full operation; mode selects lsb stimulus, drop_run releases
    // run early in CALC (must be ignored).
    task automatic check_seq(input int mode, input bit drop_run);
        int lat;
        int exp_lat;
        int ph;
        lat = 0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (drop_run && c == 3) bus.run = 1'b0;
            case (mode)
                0:       bus.lsb = 1'b0;
                1:       bus.lsb = 1'((c / 2) % 2);
                default: bus.lsb = 1'($urandom_range(0, 1));
            endcase
            #1;
            ph = (c == 1) ? 1 : ((c <= W + 1) ? 2 : 3);
            check($sformatf("seq_c%0d", c), 32'(outs()), 32'(exp_vec(ph, bus.lsb)));
            if (lat == 0 && bus.rdy) lat = c;
        end
        for (int extra = 0; extra < 8 && lat == 0; extra++) begin
            @(negedge clk);
            #1;
            if (bus.rdy) lat = LAT + 1 + extra;
        end
        exp_lat = exp_q.pop_front();
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int dummy;
        rst     = 1'b0;
        bus.run = 1'b1;
        bus.lsb = 1'b0;

        // Reset held with run high: everything quiet.
        repeat (2) begin
            @(negedge clk);
            #1 check("reset_outs", 32'(outs()), 32'h0);
        end

        // Release reset with run already high; constant lsb=0.
        start(1'b1);
        check_seq(0, 1'b0);

`ifdef CTRL_AUTO_RESTART_EN
        // run held: back-to-back operations, rdy one cycle each.
        repeat (2) begin
            exp_q.push_back(LAT);
            check_seq(1, 1'b0);
        end
        bus.run = 1'b0;
        @(negedge clk);
        #1 check("idle_after_done", 32'(outs()), 32'h0);
`else
        // DONE holds while run stays high.
        repeat (3) begin
            @(negedge clk);
            #1 check("done_hold", 32'(outs()), 32'(exp_vec(3, 1'b0)));
        end
        @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        #1 check("idle_after_done", 32'(outs()), 32'h0);

        // Toggling lsb, run dropped early in CALC.
        start(1'b0);
        check_seq(1, 1'b1);
        @(negedge clk);
        #1 check("idle_after_drop", 32'(outs()), 32'h0);

        // Random lsb, including outside CALC.
        start(1'b0);
        check_seq(2, 1'b0);
        bus.run = 1'b0;
        @(negedge clk);
        #1 check("idle_after_rand", 32'(outs()), 32'h0);
`endif

        // Asynchronous reset at CALC iteration 10.
        start(1'b0);
        repeat (12) @(negedge clk);
        bus.lsb = 1'b1;
        #1 check("calc_iter10", 32'(outs()), 32'(exp_vec(2, 1'b1)));
        #2 rst = 1'b0;
        #1 check("async_rst", 32'(outs()), 32'h0);
        dummy = exp_q.pop_front();
        repeat (3) begin
            @(negedge clk);
            #1 check("rst_hold", 32'(outs()), 32'h0);
        end
        bus.run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 check("idle_after_rst", 32'(outs()), 32'h0);

        // Restart after reset runs a full sequence.
        start(1'b0);
        check_seq(0, 1'b0);
        bus.run = 1'b0;
        @(negedge clk);
        #1 check("final_idle", 32'(outs()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
